// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8-bit UART receiver with 16x oversampling, optional parity and error flags.
module uart_rx_unit #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    input  logic       data_rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       active_flag,
    output logic       done_flag
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int DIV0 = CLK_FREQ / (2400 * OVERSAMPLE);
    localparam int DIV1 = CLK_FREQ / (4800 * OVERSAMPLE);
    localparam int DIV2 = CLK_FREQ / (9600 * OVERSAMPLE);
    localparam int DIV3 = CLK_FREQ / (19200 * OVERSAMPLE);
    localparam int CW   = $clog2(DIV0 + 1);
    localparam logic [CW-1:0] TOP0 = CW'(DIV0 - 1);
    localparam logic [CW-1:0] TOP1 = CW'(DIV1 - 1);
    localparam logic [CW-1:0] TOP2 = CW'(DIV2 - 1);
    localparam logic [CW-1:0] TOP3 = CW'(DIV3 - 1);
    state_t          state_q, state_d;
    logic            sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CW-1:0]   cnt_q, cnt_d, top;
    logic [3:0]      tcnt_q, tcnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d, data_out_q, data_out_d;
    logic            par_q, par_d;
    logic [1:0]      ptype_q, ptype_d, baud_q, baud_d;
    logic            valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic            active_q, active_d, done_q, done_d;
    logic            tick, sample;
    always_comb begin
        sync1_d    = data_rx;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ptype_d    = ptype_q;
        baud_d     = baud_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        active_d   = active_q;
        done_d     = done_q;
        top    = baud_q == 2'd0 ? TOP0 : baud_q == 2'd1 ? TOP1 : baud_q == 2'd2 ? TOP2 : TOP3;
        tick   = cnt_q == top;
        sample = tick && tcnt_q == 4'd7;
        if (state_q != IDLE) begin
            cnt_d  = tick ? '0 : cnt_q + CW'(1);
            tcnt_d = tcnt_q + 4'(tick);
        end
        case (state_q)
            IDLE: if (prev_q && !sync2_q) begin
                state_d  = START;
                cnt_d    = '0;
                tcnt_d   = 4'd0;
                ptype_d  = parity_type;
                baud_d   = baud_rate;
                active_d = 1'b1;
                done_d   = 1'b0;
            end
            START: if (sample) begin
                state_d  = sync2_q ? IDLE : DATA;
                active_d = ~sync2_q;
                idx_d    = 3'd0;
            end
            DATA: if (sample) begin
                shift_d[idx_q] = sync2_q;
                idx_d          = idx_q + 3'd1;
                if (idx_q == 3'd7)
                    state_d = (ptype_q == 2'b01 || ptype_q == 2'b10) ? PARITY : STOP;
            end
            PARITY: if (sample) begin
                par_d   = sync2_q;
                state_d = STOP;
            end
            STOP: if (sample) begin
                state_d    = IDLE;
                data_out_d = shift_q;
                valid_d    = 1'b1;
                perr_d     = ptype_q == 2'b01 ? ~(^shift_q ^ par_q) :
                             ptype_q == 2'b10 ? (^shift_q ^ par_q) : 1'b0;
                ferr_d     = ~sync2_q;
                active_d   = 1'b0;
                done_d     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            cnt_q      <= '0;
            tcnt_q     <= 4'd0;
            idx_q      <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            ptype_q    <= 2'd0;
            baud_q     <= 2'd0;
            data_out_q <= 8'd0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            ptype_q    <= ptype_d;
            baud_q     <= baud_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end
    assign data_out      = data_out_q;
    assign data_valid    = valid_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign active_flag   = active_q;
    assign done_flag     = done_q;
endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: scoreboard bench driving serial frames and checking each received strobe.
module tb_uart_rx_unit;
    localparam int CLK_FREQ = 1_920_000;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] parity_type = 2'b00;
    logic [1:0] baud_rate = 2'b00;
    logic       data_rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, parity_error, framing_error, active_flag, done_flag;
    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e;
    logic       vprev = 1'b0;

    uart_rx_unit #(.CLK_FREQ(CLK_FREQ)) dut (
        .clock(clock), .reset_n(reset_n), .parity_type(parity_type), .baud_rate(baud_rate),
        .data_rx(data_rx), .data_out(data_out), .data_valid(data_valid),
        .parity_error(parity_error), .framing_error(framing_error),
        .active_flag(active_flag), .done_flag(done_flag)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bit_cycles(input logic [1:0] b);
        return (CLK_FREQ / ((2400 << b) * 16)) * 16;
    endfunction

    task automatic drive_bit(input logic v, input int n);
        data_rx = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] br,
                              input logic pbit, input logic stop_bit);
        int   n = bit_cycles(br);
        logic pen = (pt == 2'b01) || (pt == 2'b10);
        logic perr = pt == 2'b01 ? ~(^d ^ pbit) : pt == 2'b10 ? (^d ^ pbit) : 1'b0;
        parity_type = pt;
        baud_rate   = br;
        exp_q.push_back({d, perr, ~stop_bit});
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(d[i], n);
        if (pen) drive_bit(pbit, n);
        drive_bit(stop_bit, n);
        data_rx = 1'b1;
    endtask

    task automatic wait_drain(input int maxc);
        for (int i = 0; i < maxc && exp_q.size() != 0; i++) @(negedge clock);
        check("drain", 32'(exp_q.size()), 0);
    endtask

    always @(negedge clock) begin
        if (vprev) check("valid_pulse", 32'(data_valid), 0);
        vprev = data_valid;
        if (data_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", 32'(exp_q.size()), 1);
            else begin
                e = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(e[9:2]));
                check("parity_error", 32'(parity_error), 32'(e[1]));
                check("framing_error", 32'(framing_error), 32'(e[0]));
                check("active_at_valid", 32'(active_flag), 0);
                check("done_at_valid", 32'(done_flag), 1);
            end
        end
    end

    initial begin
        logic [7:0] d6;
        int         n;
        repeat (3) @(negedge clock);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_perr", 32'(parity_error), 0);
        check("rst_ferr", 32'(framing_error), 0);
        check("rst_active", 32'(active_flag), 0);
        check("rst_done", 32'(done_flag), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        // odd parity, correct parity bit
        send_frame(8'h54, 2'b01, 2'b10, 1'b0, 1'b1);
        wait_drain(500);
        check("t1_done", 32'(done_flag), 1);
        check("t1_active", 32'(active_flag), 0);
        // even parity, wrong bit; live parity_type changes mid-frame must be ignored
        fork
            send_frame(8'h54, 2'b10, 2'b10, 1'b0, 1'b1);
            begin
                repeat (500) @(negedge clock);
                parity_type = 2'b01;
            end
        join
        wait_drain(500);
        repeat (50) @(negedge clock);
        // framing error, then recovery after line returns high
        send_frame(8'hA5, 2'b00, 2'b11, 1'b0, 1'b0);
        drive_bit(1'b1, 2 * bit_cycles(2'b11));
        check("t3_ferr_hold", 32'(framing_error), 1);
        send_frame(8'h3C, 2'b00, 2'b11, 1'b0, 1'b1);
        wait_drain(500);
        repeat (50) @(negedge clock);
        // short glitch is rejected at mid start bit
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 3);
        check("t4_active_rise", 32'(active_flag), 1);
        repeat (200) @(negedge clock);
        check("t4_active_fall", 32'(active_flag), 0);
        check("t4_done", 32'(done_flag), 0);
        check("t4_data_hold", 32'(data_out), 32'h3C);
        // back-to-back frames
        send_frame(8'h00, 2'b00, 2'b00, 1'b0, 1'b1);
        send_frame(8'hFF, 2'b00, 2'b00, 1'b0, 1'b1);
        send_frame(8'h55, 2'b00, 2'b00, 1'b0, 1'b1);
        wait_drain(2000);
        repeat (50) @(negedge clock);
        // reset in the middle of data bit 4
        d6 = 8'h54;
        parity_type = 2'b00;
        baud_rate = 2'b10;
        n = bit_cycles(2'b10);
        drive_bit(1'b0, n);
        for (int i = 0; i < 4; i++) drive_bit(d6[i], n);
        drive_bit(d6[4], n / 2);
        check("t6_active_pre", 32'(active_flag), 1);
        #3 reset_n = 1'b0;
        #1;
        check("t6_data_out", 32'(data_out), 0);
        check("t6_valid", 32'(data_valid), 0);
        check("t6_perr", 32'(parity_error), 0);
        check("t6_ferr", 32'(framing_error), 0);
        check("t6_active", 32'(active_flag), 0);
        check("t6_done", 32'(done_flag), 0);
        @(negedge clock);
        data_rx = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        send_frame(8'h41, 2'b00, 2'b10, 1'b0, 1'b1);
        wait_drain(500);
        repeat (20) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
